memory_subsystem_control: RTL and testbench



---
 rtl/msc_pkg.sv | 20 ++
 rtl/msc_prefetch_ctrl.sv | 67 ++++++
 rtl/memory_subsystem_control.sv | 90 +++++++++
 tb/tb_memory_subsystem_control.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/msc_pkg.sv
// Shared definitions for the cache control register block: register map,
// control-byte bit positions and the prefetch FSM state encoding.
package msc_pkg;

  localparam logic [1:0] MSC_P1_CTRL = 2'd0;
  localparam logic [1:0] MSC_P1_PAGE = 2'd1;
  localparam logic [1:0] MSC_P2_CTRL = 2'd2;
  localparam logic [1:0] MSC_P2_PAGE = 2'd3;

  localparam int RST_BIT   = 0;
  localparam int FLUSH_BIT = 1;
  localparam int EN_BIT    = 3;

  typedef enum logic [1:0] {
    PF_IDLE = 2'd0,
    PF_WAIT = 2'd1,
    PF_PREF = 2'd2
  } pf_state_t;

endpackage

// File: rtl/msc_prefetch_ctrl.sv
// Next-line prefetch request generator for one cache port: after a completed
// miss followed by IDLE_CYCLES+1 quiet cycles, request a prefetch until the
// cache issues its next memory request.
module msc_prefetch_ctrl
  import msc_pkg::*;
#(
  parameter int IDLE_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic inhibit,
  input  logic req,
  input  logic ready,
  output logic prefetch
);

  localparam int CW = (IDLE_CYCLES > 0) ? $clog2(IDLE_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(IDLE_CYCLES);

  pf_state_t     state, state_d;
  logic [CW-1:0] cnt, cnt_d;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering in simulation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= PF_IDLE;
      cnt      <= '0;
      prefetch <= 1'b0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      prefetch <= (state_d == PF_PREF);
    end
  end

  // NOTE: defaults are assigned first so no path leaves a variable unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    case (state)
      PF_IDLE: begin
        if (req && ready) begin
          state_d = PF_WAIT;
          cnt_d   = '0;
        end
      end
      PF_WAIT: begin
        if (req) begin
          state_d = PF_IDLE;
        end else if (cnt == CNT_MAX) begin
          state_d = PF_PREF;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      PF_PREF: begin
        if (req) state_d = PF_IDLE;
      end
      default: state_d = PF_IDLE;
    endcase
    // Cache held in reset or flush: no point prefetching into it.
    if (inhibit) state_d = PF_IDLE;
  end

endmodule

// File: rtl/memory_subsystem_control.sv
// IO-mapped control registers for the program (p1) and data (p2) caches plus
// the per-port next-line prefetch request generators.
module memory_subsystem_control
  import msc_pkg::*;
#(
  parameter int IDLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wren,
  input  logic [1:0] A,
  input  logic [7:0] data,
  output logic [7:0] p1_page,
  output logic [7:0] p2_page,
  output logic       p1_reset,
  output logic       p1_prefetch,
  output logic       p2_reset,
  output logic       p2_flush,
  output logic       p2_prefetch,
  input  logic       p1_req,
  input  logic       p2_req,
  input  logic       p1_ready,
  input  logic       p2_ready
);

  logic       rst_pending;
  logic       p1_reset_d, p2_reset_d, p2_flush_d;
  logic [7:0] p1_page_d, p2_page_d;

  always_comb begin
    // Caches are held in reset during rst and released on the first edge after.
    p1_reset_d = rst_pending ? 1'b0 : p1_reset;
    p2_reset_d = rst_pending ? 1'b0 : p2_reset;
    p2_flush_d = p2_flush;
    p1_page_d  = p1_page;
    p2_page_d  = p2_page;
    if (wren) begin
      case (A)
        MSC_P1_CTRL: if (data[EN_BIT]) p1_reset_d = data[RST_BIT];
        MSC_P1_PAGE: p1_page_d = data;
        MSC_P2_CTRL: begin
          if (data[EN_BIT]) begin
            p2_reset_d = data[RST_BIT];
            p2_flush_d = data[FLUSH_BIT];
          end
        end
        MSC_P2_PAGE: p2_page_d = data;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rst_pending <= 1'b1;
      p1_reset    <= 1'b1;
      p2_reset    <= 1'b1;
      p2_flush    <= 1'b0;
      p1_page     <= '0;
      p2_page     <= '0;
    end else begin
      rst_pending <= 1'b0;
      p1_reset    <= p1_reset_d;
      p2_reset    <= p2_reset_d;
      p2_flush    <= p2_flush_d;
      p1_page     <= p1_page_d;
      p2_page     <= p2_page_d;
    end
  end

  // Inhibit uses the post-write levels so a reset/flush write idles the FSM
  // on the same edge that sets the level.
  msc_prefetch_ctrl #(.IDLE_CYCLES(IDLE_CYCLES)) u_p1_pf (
    .clk      (clk),
    .rst      (rst),
    .inhibit  (p1_reset_d),
    .req      (p1_req),
    .ready    (p1_ready),
    .prefetch (p1_prefetch)
  );

  msc_prefetch_ctrl #(.IDLE_CYCLES(IDLE_CYCLES)) u_p2_pf (
    .clk      (clk),
    .rst      (rst),
    .inhibit  (p2_reset_d | p2_flush_d),
    .req      (p2_req),
    .ready    (p2_ready),
    .prefetch (p2_prefetch)
  );

endmodule

// File: tb/tb_memory_subsystem_control.sv
// Scoreboard bench: the driver updates a behavioural model on every edge and
// queues the expected outputs; a monitor compares them after each edge.
module tb_memory_subsystem_control;

  localparam int IDLE = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       wren;
  logic [1:0] A;
  logic [7:0] data;
  logic [7:0] p1_page, p2_page;
  logic       p1_reset, p1_prefetch, p2_reset, p2_flush, p2_prefetch;
  logic       p1_req, p2_req, p1_ready, p2_ready;

  memory_subsystem_control #(.IDLE_CYCLES(IDLE)) dut (
    .clk         (clk),
    .rst         (rst),
    .wren        (wren),
    .A           (A),
    .data        (data),
    .p1_page     (p1_page),
    .p2_page     (p2_page),
    .p1_reset    (p1_reset),
    .p1_prefetch (p1_prefetch),
    .p2_reset    (p2_reset),
    .p2_flush    (p2_flush),
    .p2_prefetch (p2_prefetch),
    .p1_req      (p1_req),
    .p2_req      (p2_req),
    .p1_ready    (p1_ready),
    .p2_ready    (p2_ready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] p1_page;
    logic [7:0] p2_page;
    logic       p1_reset;
    logic       p1_prefetch;
    logic       p2_reset;
    logic       p2_flush;
    logic       p2_prefetch;
  } out_t;

  out_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  // Reference model state: register levels plus, per port, whether a
  // completed miss is armed, how many quiet edges followed it, and prefetch.
  bit       m_p1_reset, m_p2_reset, m_flush, m_fresh;
  bit [7:0] m_page1, m_page2;
  bit       m_armed[2];
  int       m_quiet[2];
  bit       m_pref[2];

  function automatic out_t cur_out();
    return '{p1_page, p2_page, p1_reset, p1_prefetch, p2_reset, p2_flush, p2_prefetch};
  endfunction

  function automatic out_t model_out();
    return '{m_page1, m_page2, m_p1_reset, m_pref[0], m_p2_reset, m_flush, m_pref[1]};
  endfunction

  task automatic check(input string name, input out_t act, input out_t exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s t=%0t got pg1=%h pg2=%h rst1=%b pf1=%b rst2=%b fl2=%b pf2=%b expected pg1=%h pg2=%h rst1=%b pf1=%b rst2=%b fl2=%b pf2=%b",
               name, $time, act.p1_page, act.p2_page, act.p1_reset, act.p1_prefetch,
               act.p2_reset, act.p2_flush, act.p2_prefetch, exp.p1_page, exp.p2_page,
               exp.p1_reset, exp.p1_prefetch, exp.p2_reset, exp.p2_flush, exp.p2_prefetch);
    end
  endtask

  // Prefetch rises once the quiet run after a completed miss exceeds IDLE
  // edges, and drops on the first sampled request.
  function automatic void port_edge(input int p, input bit inh, input bit rq, input bit rd);
    if (inh) begin
      m_armed[p] = 1'b0;
      m_pref[p]  = 1'b0;
    end else if (m_pref[p]) begin
      if (rq) m_pref[p] = 1'b0;
    end else if (m_armed[p]) begin
      if (rq) begin
        m_armed[p] = 1'b0;
      end else begin
        m_quiet[p]++;
        if (m_quiet[p] > IDLE) begin
          m_armed[p] = 1'b0;
          m_pref[p]  = 1'b1;
        end
      end
    end else if (rq && rd) begin
      m_armed[p] = 1'b1;
      m_quiet[p] = 0;
    end
  endfunction

  function automatic void model_edge(input bit r, input bit w, input bit [1:0] a, input bit [7:0] d,
                                     input bit rq1, input bit rd1, input bit rq2, input bit rd2);
    if (r) begin
      m_p1_reset = 1'b1;
      m_p2_reset = 1'b1;
      m_flush    = 1'b0;
      m_page1    = '0;
      m_page2    = '0;
      m_fresh    = 1'b1;
      for (int i = 0; i < 2; i++) begin
        m_armed[i] = 1'b0;
        m_quiet[i] = 0;
        m_pref[i]  = 1'b0;
      end
    end else begin
      if (m_fresh) begin
        m_p1_reset = 1'b0;
        m_p2_reset = 1'b0;
        m_fresh    = 1'b0;
      end
      if (w) begin
        case (a)
          2'd0: if (d[3]) m_p1_reset = d[0];
          2'd1: m_page1 = d;
          2'd2: if (d[3]) begin m_p2_reset = d[0]; m_flush = d[1]; end
          2'd3: m_page2 = d;
        endcase
      end
      port_edge(0, m_p1_reset, rq1, rd1);
      port_edge(1, m_p2_reset || m_flush, rq2, rd2);
    end
    exp_q.push_back(model_out());
  endfunction

  // Apply one cycle of inputs; an asserted rst must show reset values at once.
  task automatic step(input bit r, input bit w, input bit [1:0] a, input bit [7:0] d,
                      input bit rq1, input bit rd1, input bit rq2, input bit rd2);
    @(negedge clk);
    rst = r; wren = w; A = a; data = d;
    p1_req = rq1; p1_ready = rd1; p2_req = rq2; p2_ready = rd2;
    model_edge(r, w, a, d, rq1, rd1, rq2, rd2);
    if (r) begin
      #1;
      check("async_reset", cur_out(), out_t'({8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0}));
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic wr(input bit [1:0] a, input bit [7:0] d);
    step(1'b0, 1'b1, a, d, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin : monitor
    out_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("edge", cur_out(), e);
      end
    end
  end

  initial begin : driver
    bit [7:0] d;
    bit [1:0] a;
    rst = 1'b1; wren = 1'b0; A = 2'd0; data = 8'h00;
    p1_req = 1'b0; p1_ready = 1'b0; p2_req = 1'b0; p2_ready = 1'b0;
    #1;
    check("power_on_reset", cur_out(), out_t'({8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0}));
    step(1'b1, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(2);

    wr(2'd0, 8'h01); idle(1);
    wr(2'd0, 8'h09); idle(1);
    wr(2'd0, 8'h08); idle(1);

    wr(2'd2, 8'h0A); idle(1);
    wr(2'd2, 8'h02); idle(1);
    wr(2'd2, 8'h08); idle(1);

    wr(2'd1, 8'h5A);
    wr(2'd3, 8'hC3);
    idle(1);

    step(1'b0, 1'b0, 2'd0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(5);
    step(1'b0, 1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(2);

    step(1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
    idle(4);
    wr(2'd2, 8'h0A);
    idle(1);
    step(1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
    idle(5);
    wr(2'd2, 8'h08);
    idle(2);

    for (int i = 0; i < 3000; i++) begin
      a = 2'($urandom_range(0, 3));
      d = 8'($urandom);
      if (a == 2'd0 || a == 2'd2) begin
        d[0] = ($urandom_range(0, 3) == 0);
        d[1] = ($urandom_range(0, 3) == 0);
      end
      step((i >= 1500 && i < 1502), ($urandom_range(0, 9) == 0), a, d,
           ($urandom_range(0, 9) < 3), ($urandom_range(0, 1) == 1),
           ($urandom_range(0, 9) < 3), ($urandom_range(0, 1) == 1));
    end
    idle(3);

    repeat (3) @(posedge clk);
    #2;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain got %0d pending expected 0 pending", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
